// File: rtl/regfile_pkg.sv
// Shared types and helpers for the parametrised register file and its scan port.
package regfile_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    SCAN = 1'b1
  } scan_state_e;

  // Widest supported register is MAX_BYTES*8 bits; callers truncate the mask to their width.
  localparam int MAX_BYTES = 16;

  function automatic logic [MAX_BYTES*8-1:0] be_to_mask(input logic [MAX_BYTES-1:0] be);
    logic [MAX_BYTES*8-1:0] mask;
    for (int b = 0; b < MAX_BYTES; b++) begin
      mask[b*8 +: 8] = {8{be[b]}};
    end
    return mask;
  endfunction

endpackage

// File: rtl/regfile_scan_ctrl.sv
// Scan-out controller: walks every register address and presents a snapshot of each
// entry over a valid/ready handshake.
module regfile_scan_ctrl
  import regfile_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              scan_start,
  input  logic              scan_ready,
  output logic              scan_busy,
  output logic              scan_valid,
  output logic [ADDR_W-1:0] scan_addr,
  output logic [DATA_W-1:0] scan_data,
  output logic              scan_last,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] rd_data
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

  scan_state_e       state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] data_q, data_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      addr_q  <= '0;
      data_q  <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
      state_q <= state_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
    end
  end

  // rd_data is the post-write array value, so a load captures any same-edge write.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    state_d = state_q;
    addr_d  = addr_q;
    data_d  = data_q;
    rd_addr = '0;
    case (state_q)
      IDLE: begin
        if (scan_start) begin
          state_d = SCAN;
          addr_d  = '0;
          data_d  = rd_data;
        end
      end
      SCAN: begin
        rd_addr = addr_q + ADDR_W'(1);
        if (scan_ready) begin
          if (addr_q == LAST_ADDR) begin
            state_d = IDLE;
          end else begin
            addr_d = rd_addr;
            data_d = rd_data;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign scan_valid = (state_q == SCAN);
  assign scan_busy  = (state_q == SCAN);
  assign scan_last  = (state_q == SCAN) && (addr_q == LAST_ADDR);
  assign scan_addr  = addr_q;
  assign scan_data  = data_q;

endmodule

// File: rtl/regfile_bypass_scan.sv
// Parametrised register file: N combinational read ports, byte-enabled write,
// optional hardwired zero register, optional write-to-read bypass and a scan-out port.
module regfile_bypass_scan
  import regfile_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int NREAD    = 2,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NREAD*ADDR_W-1:0] rd_addr,
  output logic [NREAD*DATA_W-1:0] rd_data,
  input  logic                    we,
  input  logic [ADDR_W-1:0]       wr_addr,
  input  logic [DATA_W-1:0]       wr_data,
  input  logic [DATA_W/8-1:0]     wr_be,
  input  logic                    scan_start,
  output logic                    scan_busy,
  output logic                    scan_valid,
  input  logic                    scan_ready,
  output logic [ADDR_W-1:0]       scan_addr,
  output logic [DATA_W-1:0]       scan_data,
  output logic                    scan_last
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] mem_d [DEPTH];
  logic [DATA_W-1:0] wr_mask;
  logic [DATA_W-1:0] wr_merged;
  logic              wr_en;
  logic [ADDR_W-1:0] scan_rd_addr;
  logic [DATA_W-1:0] scan_rd_data;

  assign wr_mask   = DATA_W'(be_to_mask(MAX_BYTES'(wr_be)));
  assign wr_en     = we && !((ZERO_REG != 0) && (wr_addr == '0));
  assign wr_merged = (mem_q[wr_addr] & ~wr_mask) | (wr_data & wr_mask);

  always_comb begin
    mem_d = mem_q;
    if (wr_en) begin
      mem_d[wr_addr] = wr_merged;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      // NOTE: the architectural state must come up zeroed, so this array is reset as flops
      // rather than mapped to an unresettable RAM macro.
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      mem_q <= mem_d;
    end
  end

  for (genvar i = 0; i < NREAD; i++) begin : g_rd
    logic [ADDR_W-1:0] ra;
    logic              hit;
    assign ra  = rd_addr[i*ADDR_W +: ADDR_W];
    assign hit = (BYPASS != 0) && wr_en && (wr_addr == ra);
    assign rd_data[i*DATA_W +: DATA_W] =
        ((ZERO_REG != 0) && (ra == '0)) ? '0 :
        hit                             ? wr_merged : mem_q[ra];
  end

  assign scan_rd_data = mem_d[scan_rd_addr];

  regfile_scan_ctrl #(
    .DATA_W(DATA_W),
    .ADDR_W(ADDR_W)
  ) u_scan (
    .clk       (clk),
    .reset     (reset),
    .scan_start(scan_start),
    .scan_ready(scan_ready),
    .scan_busy (scan_busy),
    .scan_valid(scan_valid),
    .scan_addr (scan_addr),
    .scan_data (scan_data),
    .scan_last (scan_last),
    .rd_addr   (scan_rd_addr),
    .rd_data   (scan_rd_data)
  );

endmodule

// File: tb/tb_regfile_bypass_scan.sv
// Directed bench for regfile_bypass_scan: default, no-bypass and 4-port/16-bit instances.
module tb_regfile_bypass_scan;

  logic        clk;
  logic        reset;
  logic [9:0]  rd_addr;
  logic [63:0] rd_data, nb_rd_data;
  logic        we;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data;
  logic [3:0]  wr_be;
  logic        scan_start, scan_ready;
  logic        scan_busy, scan_valid, scan_last;
  logic [4:0]  scan_addr;
  logic [31:0] scan_data;
  logic        nb_busy, nb_valid, nb_last;
  logic [4:0]  nb_addr;
  logic [31:0] nb_data;

  logic [11:0] rd_addr4;
  logic [63:0] rd_data4;
  logic        we4;
  logic [2:0]  wr_addr4;
  logic [15:0] wr_data4;
  logic [1:0]  wr_be4;
  logic        scan_start4, scan_ready4;
  logic        busy4, valid4, last4;
  logic [2:0]  addr4;
  logic [15:0] data4;

  int total = 0;
  int bad   = 0;

  regfile_bypass_scan dut (
    .clk(clk), .reset(reset), .rd_addr(rd_addr), .rd_data(rd_data),
    .we(we), .wr_addr(wr_addr), .wr_data(wr_data), .wr_be(wr_be),
    .scan_start(scan_start), .scan_busy(scan_busy), .scan_valid(scan_valid),
    .scan_ready(scan_ready), .scan_addr(scan_addr), .scan_data(scan_data),
    .scan_last(scan_last)
  );

  regfile_bypass_scan #(.BYPASS(0)) dut_nb (
    .clk(clk), .reset(reset), .rd_addr(rd_addr), .rd_data(nb_rd_data),
    .we(we), .wr_addr(wr_addr), .wr_data(wr_data), .wr_be(wr_be),
    .scan_start(1'b0), .scan_busy(nb_busy), .scan_valid(nb_valid),
    .scan_ready(1'b0), .scan_addr(nb_addr), .scan_data(nb_data),
    .scan_last(nb_last)
  );

  regfile_bypass_scan #(.DATA_W(16), .ADDR_W(3), .NREAD(4)) dut4 (
    .clk(clk), .reset(reset), .rd_addr(rd_addr4), .rd_data(rd_data4),
    .we(we4), .wr_addr(wr_addr4), .wr_data(wr_data4), .wr_be(wr_be4),
    .scan_start(scan_start4), .scan_busy(busy4), .scan_valid(valid4),
    .scan_ready(scan_ready4), .scan_addr(addr4), .scan_data(data4),
    .scan_last(last4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d, input logic [3:0] be);
    we = 1'b1; wr_addr = a; wr_data = d; wr_be = be;
    tick();
    we = 1'b0;
  endtask

  task automatic wr4(input logic [2:0] a, input logic [15:0] d, input logic [1:0] be);
    we4 = 1'b1; wr_addr4 = a; wr_data4 = d; wr_be4 = be;
    tick();
    we4 = 1'b0;
  endtask

  task automatic check_scan(input string tag, input logic [4:0] a, input logic [31:0] d,
                            input logic last);
    check({tag, ".valid"}, {31'd0, scan_valid}, 32'd1);
    check({tag, ".addr"}, {27'd0, scan_addr}, {27'd0, a});
    check({tag, ".data"}, scan_data, d);
    check({tag, ".last"}, {31'd0, scan_last}, {31'd0, last});
  endtask

  logic [15:0] e4;

  initial begin
    reset = 1'b1;
    rd_addr = '0; we = 1'b0; wr_addr = '0; wr_data = '0; wr_be = '0;
    scan_start = 1'b0; scan_ready = 1'b0;
    rd_addr4 = '0; we4 = 1'b0; wr_addr4 = '0; wr_data4 = '0; wr_be4 = '0;
    scan_start4 = 1'b0; scan_ready4 = 1'b0;
    #12;
    check("rst.valid", {31'd0, scan_valid}, 32'd0);
    check("rst.busy", {31'd0, scan_busy}, 32'd0);
    check("rst.last", {31'd0, scan_last}, 32'd0);
    check("rst.addr", {27'd0, scan_addr}, 32'd0);
    check("rst.data", scan_data, 32'd0);
    tick();
    reset = 1'b0;
    tick();

    for (int k = 0; k < 32; k++) begin
      rd_addr = {5'(31 - k), 5'(k)};
      #1;
      check($sformatf("rst.rd0[%0d]", k), rd_data[31:0], 32'd0);
      check($sformatf("rst.rd1[%0d]", 31 - k), rd_data[63:32], 32'd0);
    end

    // Byte-enabled writes, be=0 no-op, and zero register.
    wr(5'd5, 32'hDEADBEEF, 4'hF);
    wr(5'd5, 32'h0000AA00, 4'b0010);
    wr(5'd5, 32'h11111111, 4'h0);
    wr(5'd0, 32'hFFFFFFFF, 4'hF);
    rd_addr = {5'd0, 5'd5};
    #1;
    check("be.reg5", rd_data[31:0], 32'hDEADAAEF);
    check("zero.reg0", rd_data[63:32], 32'd0);

    // Same-cycle bypass versus no bypass; partial-byte bypass on port 1.
    we = 1'b1; wr_addr = 5'd9; wr_data = 32'h12345678; wr_be = 4'hF;
    rd_addr = {5'd9, 5'd9};
    #1;
    check("byp.rd0", rd_data[31:0], 32'h12345678);
    check("byp.rd1", rd_data[63:32], 32'h12345678);
    check("nobyp.rd0", nb_rd_data[31:0], 32'd0);
    wr_addr = 5'd5; wr_data = 32'h00000077; wr_be = 4'b0001;
    rd_addr = {5'd5, 5'd5};
    #1;
    check("byp.part", rd_data[63:32], 32'hDEADAA77);
    check("nobyp.part", nb_rd_data[63:32], 32'hDEADAAEF);
    wr_addr = 5'd9; wr_data = 32'h12345678; wr_be = 4'hF;
    tick();
    we = 1'b0;
    rd_addr = {5'd0, 5'd9};
    #1;
    check("nobyp.after", nb_rd_data[31:0], 32'h12345678);
    we = 1'b1; wr_addr = 5'd0; rd_addr = {5'd0, 5'd0};
    #1;
    check("byp.zero", rd_data[31:0], 32'd0);
    we = 1'b0;

    // Full scan of reg k = k*3 with ready held high.
    for (int k = 0; k < 32; k++) wr(5'(k), 32'(k * 3), 4'hF);
    scan_start = 1'b1; scan_ready = 1'b1;
    tick();
    scan_start = 1'b0;
    check("scan.busy", {31'd0, scan_busy}, 32'd1);
    for (int k = 0; k < 32; k++) begin
      check_scan($sformatf("scan[%0d]", k), 5'(k), 32'(k * 3), k == 31);
      tick();
    end
    check("scan.end.valid", {31'd0, scan_valid}, 32'd0);
    check("scan.end.busy", {31'd0, scan_busy}, 32'd0);
    check("scan.end.last", {31'd0, scan_last}, 32'd0);

    // Stall at entry 4 while rewriting reg4; start pulses must be ignored.
    scan_start = 1'b1;
    tick();
    scan_start = 1'b0;
    for (int k = 0; k < 4; k++) tick();
    check_scan("stall.pre", 5'd4, 32'd12, 1'b0);
    scan_ready = 1'b0; scan_start = 1'b1;
    we = 1'b1; wr_addr = 5'd4; wr_data = 32'h55; wr_be = 4'hF;
    tick();
    we = 1'b0;
    for (int c = 0; c < 3; c++) begin
      check_scan($sformatf("stall[%0d]", c), 5'd4, 32'd12, 1'b0);
      if (c < 2) tick();
    end
    rd_addr = {5'd0, 5'd4};
    #1;
    check("stall.reg4", rd_data[31:0], 32'h55);
    scan_start = 1'b0; scan_ready = 1'b1;
    tick();
    check_scan("resume[5]", 5'd5, 32'd15, 1'b0);
    tick();
    tick();
    check_scan("resume[7]", 5'd7, 32'd21, 1'b0);

    // Asynchronous reset in the middle of the scan.
    reset = 1'b1;
    #1;
    check("midrst.valid", {31'd0, scan_valid}, 32'd0);
    check("midrst.busy", {31'd0, scan_busy}, 32'd0);
    check("midrst.addr", {27'd0, scan_addr}, 32'd0);
    check("midrst.reg4", rd_data[31:0], 32'd0);
    tick();
    reset = 1'b0;
    for (int c = 0; c < 3; c++) tick();
    check("midrst.idle", {31'd0, scan_valid}, 32'd0);

    // Four-port, 16-bit, 8-entry instance.
    for (int k = 0; k < 8; k++) wr4(3'(k), 16'(16'h1000 + k), 2'b11);
    wr4(3'd3, 16'hFFAB, 2'b01);
    rd_addr4 = {3'd7, 3'd3, 3'd2, 3'd0};
    #1;
    check("p4.a.rd0", {16'd0, rd_data4[15:0]}, 32'h0000);
    check("p4.a.rd1", {16'd0, rd_data4[31:16]}, 32'h1002);
    check("p4.a.rd2", {16'd0, rd_data4[47:32]}, 32'h10AB);
    check("p4.a.rd3", {16'd0, rd_data4[63:48]}, 32'h1007);
    rd_addr4 = {3'd5, 3'd5, 3'd1, 3'd6};
    #1;
    check("p4.b.rd0", {16'd0, rd_data4[15:0]}, 32'h1006);
    check("p4.b.rd1", {16'd0, rd_data4[31:16]}, 32'h1001);
    check("p4.b.rd2", {16'd0, rd_data4[47:32]}, 32'h1005);
    check("p4.b.rd3", {16'd0, rd_data4[63:48]}, 32'h1005);
    scan_start4 = 1'b1; scan_ready4 = 1'b1;
    tick();
    scan_start4 = 1'b0;
    for (int k = 0; k < 8; k++) begin
      e4 = (k == 0) ? 16'h0 : (k == 3) ? 16'h10AB : 16'(16'h1000 + k);
      check($sformatf("s4[%0d].valid", k), {31'd0, valid4}, 32'd1);
      check($sformatf("s4[%0d].addr", k), {29'd0, addr4}, 32'(k));
      check($sformatf("s4[%0d].data", k), {16'd0, data4}, {16'd0, e4});
      check($sformatf("s4[%0d].last", k), {31'd0, last4}, {31'd0, k == 7});
      tick();
    end
    check("s4.end.valid", {31'd0, valid4}, 32'd0);
    check("s4.end.busy", {31'd0, busy4}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/regfile_bypass_scan.md
Name: regfile_bypass_scan

Overview:
- Parametrised general-purpose register file for the MIPS datapath; successor to the fixed 32x32, 2-read register file.
- Adds N read ports, byte-enabled writes, a hardwired zero register and same-cycle write-to-read bypass.
- Adds a handshaked scan-out port that streams every register over valid/ready, replacing simulation-only dumps with a synthesizable debug path.
- Sits between decode (read addresses) and writeback (write port); the scan port goes to the debug/trace unit.

Parameters:
- DATA_W, 32, register width in bits (multiple of 8).
- ADDR_W, 5, address width; DEPTH = 2**ADDR_W.
- NREAD, 2, number of combinational read ports (1..4).
- ZERO_REG, 1, 1 = register 0 reads 0 and ignores writes.
- BYPASS, 1, 1 = a read of the address being written this cycle returns the merged write data.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- rd_addr  in  NREAD*ADDR_W  packed read addresses; port i at [i*ADDR_W +: ADDR_W].
- rd_data  out  NREAD*DATA_W  packed read data, combinational.
- we  in  1  write enable.
- wr_addr  in  ADDR_W  write address.
- wr_data  in  DATA_W  write data.
- wr_be  in  DATA_W/8  byte enables; bit b covers byte b.
- scan_start  in  1  pulse that starts a full-file scan.
- scan_busy  out  1  high from scan accept until the last handshake.
- scan_valid  out  1  scan entry valid.
- scan_ready  in  1  consumer ready.
- scan_addr  out  ADDR_W  address of the presented entry.
- scan_data  out  DATA_W  snapshot of the presented entry.
- scan_last  out  1  presented entry is DEPTH-1.

Behaviour:
- Reset (async, active-high): all DEPTH registers cleared to 0. FSM enters IDLE. scan_busy, scan_valid and scan_last are 0; scan_addr and scan_data are 0.
- Reset mid-scan aborts the scan; no further entries are emitted.
- Write: at posedge, when we=1 and not (ZERO_REG and wr_addr==0), each byte b with wr_be[b]=1 takes wr_data byte b. Other bytes are kept.
- we=1 with wr_be=0 is a no-op.
- Read: combinational, rd_data_i = reg[rd_addr_i]. If ZERO_REG and rd_addr_i==0, the result is 0.
- Bypass: if BYPASS, we=1, wr_addr==rd_addr_i and the address is not a suppressed zero register, rd_data_i = (old & ~mask) | (wr_data & mask), where mask is wr_be expanded per byte.
- If BYPASS=0, a read returns the pre-write value until the next cycle.
- Multiple read ports addressing the same register all get identical data.
- Scan FSM states: IDLE, SCAN.
  - IDLE: scan_start=1 at edge N moves to SCAN. At edge N, scan_addr=0, scan_data=reg[0] is captured and scan_valid=1, scan_busy=1, visible after edge N.
  - SCAN: scan_addr, scan_data and scan_last are held stable while scan_valid && !scan_ready.
  - SCAN: on a handshake (valid && ready) with addr < DEPTH-1, the next edge loads addr+1 and its data. Throughput is one entry per cycle with ready held high.
  - SCAN: on a handshake with scan_last=1, the FSM returns to IDLE; scan_valid and scan_busy fall at that edge.
- scan_data is snapshot semantics: the value is captured at load, using the post-write value of any same-edge write. A later write to the held address does not change the presented scan_data.
- scan_start while busy is ignored.
- A full scan with ready held high takes DEPTH cycles from start to last handshake.
- Reads and writes are fully independent of scan activity.

Decomposition:
- Shared package regfile_pkg holds:
  - scan FSM state enum {IDLE, SCAN};
  - function be_to_mask(wr_be) returning the DATA_W bit mask.
- Sub-module regfile_scan_ctrl is natural. It owns the FSM, address counter and snapshot register, and reads the array through one internal read port. The top level owns the storage array, write logic and bypass muxes.

Test Plan:
- Reset then read all 32 addresses on both ports -> all 0; assert reset mid-scan at entry 7 -> scan_valid=0 and scan_busy=0 immediately, FSM IDLE.
- Write reg5=0xDEADBEEF with be=4'hF, then be=4'b0010 data 0x0000AA00 -> reg5=0xDEADAAEF; write reg0=0xFFFFFFFF -> reads 0.
- Same cycle: we, wr_addr=9, data 0x12345678, be=4'hF, rd_addr0=9 -> rd_data0=0x12345678 with BYPASS=1; old value 0 with BYPASS=0.
- Preload reg k = k*3, scan_start, ready high -> 32 consecutive entries (0,0),(1,3)..(31,93); scan_last only on 31; busy drops the cycle after.
- Scan with ready low 3 cycles at addr 4 while writing reg4=0x55 -> addr and data stay 4 and 12 (stable snapshot); scan_start pulses during the scan are ignored.
- NREAD=4, ADDR_W=3, DATA_W=16 instance: four ports reading distinct addresses return correct values; 8-entry scan terminates with scan_last at addr 7.
